// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD shifter:
//   state_e        - converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W    - width of one packed BCD digit
//   ADD3_THRESHOLD - digit value at or above which the shift-and-add-3 step
//                    adds 3 before the next left shift
//   pow10()        - constant helper used to check the DIGITS/WIDTH sizing
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // 10^n as a 64-bit value, evaluated at elaboration time.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell for one BCD digit: a digit of
// 5 or more gets +3 (4-bit add, no carry out) so that the following left
// shift carries correctly into the next decimal digit.
// Ports:
//   i_digit - current BCD digit
//   o_digit - corrected digit, ready to be shifted
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Add-3 correction for digits at or above the threshold.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADD3_THRESHOLD) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bcd_shifter.sv
// -----------------------------------------------------------------------------
// bcd_shifter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts a sample in IDLE, shifts for WIDTH cycles in SHIFT, then presents
// the result in DONE until the consumer takes it. Samples offered while busy
// are dropped, not queued.
//
// Optional feature macro: BCD_SHIFTER_WRAP_DETECT_EN
//   When defined, out_wrap flags an accepted sample smaller than the previous
//   accepted one (modulo wrap of a monotonic producer). When undefined,
//   out_wrap is tied low and no wrap state is built.
//
// Parameters:
//   WIDTH  - binary input width
//   DIGITS - number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset
//   in_data   - binary sample
//   in_valid  - in_data valid
//   in_ready  - converter idle and able to accept (state == IDLE)
//   out_bcd   - packed BCD result, most significant digit in the top nibble
//   out_valid - result valid (state == DONE)
//   out_ready - consumer accepts the result
//   out_wrap  - producer wrap flag, qualified by out_valid
// -----------------------------------------------------------------------------
module bcd_shifter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_wrap
);

  localparam int             BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  // Too few digits would silently lose high-order bits of the result.
  if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_digits_too_small
    $error("bcd_shifter: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH)");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_bcd_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_bcd   = r_bcd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, one corrected shift per SHIFT cycle, hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin <= in_data;
            r_bcd <= '0;
            r_cnt <= CNT_LOAD;
          end
        end
        SHIFT: begin
          // The sizing check guarantees the bit shifted out of the top is 0.
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          if (r_cnt != CNT_W'(0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_bcd <= r_bcd;
        end
      endcase
    end
  end

`ifdef BCD_SHIFTER_WRAP_DETECT_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_wrap;

  // Wrap detection: compare each accepted sample against the previous one.
  // r_prev resets to 0, so the first sample after reset can never flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_wrap <= 1'b0;
    end else if (w_accept) begin
      r_wrap <= (in_data < r_prev);
      r_prev <= in_data;
    end
  end

  assign out_wrap = r_wrap & out_valid;
`else
  assign out_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_shifter.sv
// -----------------------------------------------------------------------------
// tb_bcd_shifter
// Self-checking bench for bcd_shifter at default parameters (WIDTH=8,
// DIGITS=3): a table of directed conversions plus hand-written sequences for
// backpressure, busy drop with a Fibonacci producer, reset mid-conversion and
// the wrap flag.
// -----------------------------------------------------------------------------
module tb_bcd_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] out_bcd;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_wrap;

  int n_checks = 0;
  int n_errors = 0;
  int prev_model = 0;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[9];

  bcd_shifter #(.WIDTH(8), .DIGITS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wrap  (out_wrap)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) << 8) | 12'(((v / 10) % 10) << 4) | 12'(v % 10);
  endfunction

  function automatic logic wrap_model(input int d);
`ifdef BCD_SHIFTER_WRAP_DETECT_EN
    return (d < prev_model) ? 1'b1 : 1'b0;
`else
    return (d < 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      step();
      k++;
    end
    if (!in_ready) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // One conversion with out_ready held 1: checks latency, result, wrap, return to IDLE.
  task automatic convert(input logic [7:0] d, input logic [11:0] bcd, input string tag);
    int   k;
    logic ew;
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
    ew = wrap_model(int'(d));
    prev_model = int'(d);
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_latency"}, k, 32'd8);
    check({tag, "_bcd"}, {20'd0, out_bcd}, {20'd0, bcd});
    check({tag, "_wrap"}, {31'd0, out_wrap}, {31'd0, ew});
    step();
    check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int          k;
    int          last_acc;
    int          n_out;
    int          fa;
    int          fb;
    int          ft;
    int          q[$];
    int          e;
    logic [11:0] held;

    vecs[0] = '{8'd233, 12'h233};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd255, 12'h255};
    vecs[3] = '{8'd89,  12'h089};
    vecs[4] = '{8'd13,  12'h013};
    vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd99,  12'h099};
    vecs[7] = '{8'd9,   12'h009};
    vecs[8] = '{8'd10,  12'h010};

    // Reset state while reset is held low.
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bcd", {20'd0, out_bcd}, 32'd0);
    check("rst_out_wrap", {31'd0, out_wrap}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven conversions.
    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].din, vecs[i].bcd, $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    out_ready = 1'b0;
    wait_ready();
    in_data  = 8'd144;
    in_valid = 1'b1;
    prev_model = 144;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("bp_latency", k, 32'd8);
    held = out_bcd;
    check("bp_bcd", {20'd0, held}, 32'h144);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_stable_c%0d", c), {20'd0, out_bcd}, 32'h144);
      check($sformatf("bp_noready_c%0d", c), {31'd0, in_ready}, 32'd0);
      if (c < 4) step();
    end
    out_ready = 1'b1;
    step();
    check("bp_handshake", {30'd0, out_valid, in_ready}, 32'd1);
    step();
    check("bp_single", {31'd0, out_valid}, 32'd0);

    // Busy drop: Fibonacci producer with in_valid always high.
    fa = 0;
    fb = 1;
    last_acc = -1;
    n_out = 0;
    for (int i = 0; i < 80; i++) begin
      in_data  = 8'(fa);
      in_valid = 1'b1;
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("busy_bcd", {20'd0, out_bcd}, {20'd0, to_bcd(e & 255)});
          check("busy_wrap", {31'd0, out_wrap}, {31'd0, e[8]});
        end else begin
          check("busy_unexpected_out", {31'd0, out_valid}, 32'd0);
        end
        n_out++;
      end
      if (in_ready) begin
        if (last_acc >= 0) check("busy_period", {31'd0, (i - last_acc) >= 10}, 32'd1);
        last_acc = i;
        q.push_back(fa | (int'(wrap_model(fa)) << 8));
        prev_model = fa;
      end
      step();
      ft = (fa + fb) & 255;
      fa = fb;
      fb = ft;
    end
    in_valid = 1'b0;
    check("busy_n_out", n_out, 32'd8);
    check("busy_q_empty", q.size(), 32'd0);

    // Reset three cycles after accept aborts the conversion.
    wait_ready();
    in_data  = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    prev_model = 0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_bcd", {20'd0, out_bcd}, 32'd0);
    #2;
    reset = 1'b1;
    step();
    check("mid_no_out", {31'd0, out_valid}, 32'd0);
    convert(8'd13, 12'h013, "after_rst");

    // Wrap sequence from a fresh reset.
    reset = 1'b0;
    prev_model = 0;
    #3;
    reset = 1'b1;
    step();
    convert(8'd233, 12'h233, "wrap_a");
    convert(8'd121, 12'h121, "wrap_b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_shifter.md
# bcd_shifter

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit Fibonacci sequence generator. It converts each accepted sample to packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. Its output feeds the decimal display or print stage. A valid/ready handshake on both sides lets it drop samples from a free-running producer while busy and hold its result under backpressure.

## Interface
Parameters:
- WIDTH, default 8: binary input width.
- DIGITS, default 3: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH; elaboration fails otherwise.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. Asserting (0) clears all state immediately.
- in_data, input, WIDTH: binary sample.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: converter can accept a sample. Equals (state == IDLE).
- out_bcd, output, 4*DIGITS: packed BCD result, most significant digit in the top nibble.
- out_valid, output, 1: out_bcd (and out_wrap) are valid.
- out_ready, input, 1: consumer accepts the result this cycle.
- out_wrap, output, 1: producer wrap flag (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load the shift register with in_data, clear the BCD accumulator, load the bit counter with WIDTH-1, go to SHIFT.
- SHIFT, one step per cycle:
  - Every digit ≥5 gets +3 (4-bit add, no carry between digits).
  - Then shift {bcd, bin} left by one bit.
  - When the counter reaches 0, go to DONE; otherwise decrement the counter.
  - in_valid is ignored; the sample is dropped, not queued.
- DONE:
  - out_valid=1; out_bcd is held stable.
  - On out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE, so no accept happens in the same cycle as the output handshake.
- Arithmetic:
  - Accumulator width is 4*DIGITS.
  - The constraint on DIGITS guarantees no bits are lost.
  - Any digit above 9 is a design error.
- Reset values: state=IDLE, out_valid=0, out_bcd=0, out_wrap=0, in_ready=1 while reset is low and after release.
- Reset mid-operation: aborts the conversion, returns to IDLE, and discards the partial result. No out_valid is produced for the aborted sample.

## Timing
- Accept at rising edge N (IDLE & in_valid).
- out_valid rises after edge N+WIDTH (8 cycles at default).
- Result is held until the first edge where out_ready=1. out_valid falls after that edge.
- Next accept can occur no earlier than the edge after the output handshake.
- Minimum sample period: WIDTH+2 cycles.
- in_ready and out_valid are pure decodes of registered state; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: BCD_SHIFTER_WRAP_DETECT_EN.
- Defined:
  - A WIDTH-bit register holds the previous accepted in_data, reset to 0.
  - On accept, a wrap bit is registered as (in_data < previous). previous is then updated.
  - out_wrap presents the wrap bit, qualified by out_valid.
  - This flags modulo-2^WIDTH overflow of a monotonic producer.
  - The first sample after reset never flags.
- Undefined: out_wrap is tied to 0 and neither register is built.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - BCD_DIGIT_W=4;
  - ADD3_THRESHOLD=5.
- One sub-module: bcd_digit_adj. It is a combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times in a generate loop.
- The top level holds the FSM, counter, shift registers and the wrap logic.

## Test plan
- Conversion: in_data=233 with out_ready held 1 → out_valid exactly 8 cycles after accept, out_bcd=12'h233, then IDLE.
- Extremes: 0 → 12'h000; 255 → 12'h255; 89 → 12'h089.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_bcd and out_valid are stable for all 5 cycles; single handshake when out_ready=1.
- Busy drop: in_valid held 1 with data changing every cycle (Fibonacci generator driving it) → only samples present at IDLE edges are converted, each result is correct, and period ≥10 cycles.
- Reset mid-SHIFT: assert reset 3 cycles after accept → in_ready=1 and out_valid=0 immediately; the next sample of 13 → 12'h013 with no stale digits.
- Wrap (macro defined): accept 233 then 121 → first out_wrap=0, second out_wrap=1. With the macro undefined, out_wrap is always 0.
